mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Round-robin arbiter and sequencer for the shared 8:1 single-bit mux path. Eight requesters compete for the one shared output line. The block grants one requester at a time, drives the 3-bit mux select, and enforces a maximum hold time plus a one-cycle dead gap between owners. It sits directly in front of the 8:1 mux and contains the gated mux output so that downstream logic sees a clean `dout`.

## Interface
- `MAX_HOLD`, default 4: maximum grant length in cycles while other requesters are pending; legal range 2..16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request per requester; bit i is held high for as long as requester i wants the line.
- `din`  in  8  data bit per requester; bit i is requester i's data.
- `sel`  out  3  mux select; the index of the current owner.
- `gnt`  out  8  one-hot grant; all zeros when there is no owner.
- `gnt_valid`  out  1  high while in GRANT.
- `dout`  out  1  equals `din[sel]` when `gnt_valid` is high, otherwise 0 (combinational).
- `preempt`  out  1  one-cycle pulse in the cycle after a forced release.

## Operation
- **States:** IDLE, GRANT, GAP. Reset state is IDLE.
- **Registers:**
  - `ptr` (3 b): round-robin pointer.
  - `hold_cnt` (4 b).
  - `sel`, `gnt`, `preempt`.
- **Arbitration**, performed in IDLE and GAP: the winner is the first index i in the order ptr, ptr+1, …, 7, 0, …, ptr−1 (mod 8) with `req[i]` = 1.
  - If any request is present: go to GRANT, set `sel` = winner, set `gnt` = 1<<winner, clear `hold_cnt` to 0.
  - If no request is present: go to or stay in IDLE.
- **GRANT** is evaluated each edge, in priority order:
  1. **Natural release.** Condition: `req[sel]` = 0. Go to GAP, clear `gnt`, set `ptr` = sel+1 mod 8 (7 wraps to 0).
  2. **Forced release.** Condition: `hold_cnt` == MAX_HOLD−1 and (`req` & ~`gnt`) ≠ 0. Go to GAP, clear `gnt`, set `ptr` = sel+1 mod 8, pulse `preempt` for 1 cycle.
  3. **Otherwise:** stay in GRANT and increment `hold_cnt`, saturating at MAX_HOLD−1. A sole requester therefore keeps the line indefinitely.
- **GAP** always lasts exactly 1 cycle with `gnt` = 0. Arbitration then proceeds as in IDLE, using the updated `ptr`.
- **Held outputs:**
  - `sel` holds its last value in IDLE and GAP (no spurious select toggling).
  - `dout` is forced to 0 in IDLE and GAP.
- **Reset:** asserting `rst_n` low at any time, including mid-grant, immediately clears state to IDLE and clears `ptr`, `hold_cnt`, `sel`, `gnt` and `preempt` to 0. `dout` goes to 0.

## Timing
- **Reset values:** `sel`=0, `gnt`=0, `gnt_valid`=0, `dout`=0, `preempt`=0.
- **Grant latency:** a request sampled high at edge k while in IDLE gives a grant visible after edge k (1 cycle).
- **Release:** `req[sel]` low at edge k gives `gnt` low after edge k.
  - A waiting requester is granted after edge k+1.
  - Minimum dead time between owners is exactly 1 cycle.
- **Forced release:**
  - The owner holds the line for exactly MAX_HOLD cycles.
  - `preempt` is high during the GAP cycle only.
- **Simultaneous events:**
  - Owner drops `req` on the same edge as a timeout: treated as a natural release, `preempt` stays 0.
  - New requests arriving during GRANT do not change `sel` until a release.
- **Output timing:**
  - `gnt` is always one-hot or zero, and `gnt[sel]` == `gnt_valid`.
  - `dout` follows `din` combinationally during GRANT.

## Test plan
- **Reset and single request:**
  - Stimulus: reset, then `req`=8'h10 with `din`=8'h10.
  - Required: 1 cycle later `sel`=4, `gnt`=8'h10, `dout`=1.
  - Then drop `req`: one GAP cycle, then IDLE with `gnt`=0 and `dout`=0.
- **Round-robin wrap:**
  - Stimulus: `req`=8'h81 held high with MAX_HOLD=4.
  - Required: grant sequence is 0 (4 cycles), GAP, 7 (4 cycles), GAP, 0; `preempt` pulses in each GAP; `ptr` wraps 7→0.
- **Sole holder:**
  - Stimulus: `req`=8'h04 held for 20 cycles.
  - Required: continuous grant to 2, no `preempt`, `hold_cnt` saturates at 3.
- **Release/timeout tie:**
  - Stimulus: owner 1 drops `req` in the same cycle that `hold_cnt` hits 3, while `req[5]`=1.
  - Required: `preempt`=0, then after GAP `sel`=5.
- **Reset mid-grant:**
  - Stimulus: assert `rst_n`=0 asynchronously (between edges) during a grant to 6.
  - Required: `gnt`=0, `sel`=0 and `dout`=0 immediately; after release, `req`=8'hFF grants 0 first.
- **All requesters:**
  - Stimulus: `req`=8'hFF for 80 cycles, `din`=8'hAA.
  - Required: grants 0..7 in order, 4 cycles each; `dout` = `sel`[0] during each grant.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for a shared 8:1 single-bit mux: one owner at a time, bounded hold, one-cycle dead gap.
// Grant visible one cycle after request; no backpressure, owners are preempted after MAX_HOLD cycles when others wait.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       dout,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] sel_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [7:0] gnt_nxt;
  logic       preempt_nxt;
  logic [2:0] win;
  logic [2:0] idx;
  logic       any_req;

  // Scan from the far end back toward ptr so the last hit is the first in round-robin order.
  always_comb begin
    win     = '0;
    idx     = '0;
    any_req = |req;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) win = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      sel      <= '0;
      gnt      <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      sel      <= sel_nxt;
      gnt      <= gnt_nxt;
      preempt  <= preempt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    gnt_nxt     = gnt;
    hold_nxt    = hold_cnt;
    preempt_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (any_req) begin
          state_nxt = GRANT;
          sel_nxt   = win;
          gnt_nxt   = 8'b1 << win;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        // Owner dropping its request wins over a coincident timeout: no preempt pulse.
        if (!req[sel]) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          ptr_nxt   = sel + 3'd1;
        end else if (hold_cnt == HOLD_LAST && |(req & ~gnt)) begin
          state_nxt   = GAP;
          gnt_nxt     = '0;
          ptr_nxt     = sel + 3'd1;
          preempt_nxt = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_valid = (state == GRANT);
  assign dout      = gnt_valid & din[sel];

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with hand-computed expected output vectors.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       dout;
  logic       preempt;

  int total = 0;
  int bad   = 0;

  logic [13:0] obs;
  logic [13:0] exp_v;
  assign obs = {sel, gnt, gnt_valid, dout, preempt};

  mux_sel_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid), .dout(dout), .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    din   = 8'hFF;
    repeat (2) tick();
    exp_v = '0;
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    req   = '0;
    rst_n = 1'b1;
    tick();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_single();
    apply_reset();
    req = 8'h10;
    din = 8'h10;
    tick();
    exp_v = {3'd4, 8'h10, 1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL single_grant: got %h want %h", obs, exp_v); end
    req = '0;
    tick();
    exp_v = {3'd4, 8'h00, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL single_gap: got %h want %h", obs, exp_v); end
    tick();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL single_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_wrap();
    apply_reset();
    req = 8'h81;
    din = 8'h81;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        exp_v = {(r == 0) ? 3'd0 : 3'd7, (r == 0) ? 8'h01 : 8'h80, 1'b1, 1'b1, 1'b0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL wrap_grant r%0d c%0d: got %h want %h", r, c, obs, exp_v); end
      end
      tick();
      exp_v = {(r == 0) ? 3'd0 : 3'd7, 8'h00, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL wrap_gap r%0d: got %h want %h", r, obs, exp_v); end
      total++;
      if (dut.ptr !== ((r == 0) ? 3'd1 : 3'd0)) begin
        bad++; $display("FAIL wrap_ptr r%0d: got %0d want %0d", r, dut.ptr, (r == 0) ? 1 : 0);
      end
    end
    tick();
    exp_v = {3'd0, 8'h01, 1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap_back0: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_sole();
    apply_reset();
    req = 8'h04;
    din = 8'h00;
    tick();
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_v = {3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v || dut.hold_cnt !== ((c < 3) ? 4'(c) : 4'd3)) begin
        bad++; $display("FAIL sole c%0d: got %h hold %0d want %h hold %0d", c, obs, dut.hold_cnt, exp_v, (c < 3) ? c : 3);
      end
    end
  endtask

  task automatic test_tie();
    apply_reset();
    req = 8'h22;
    din = 8'h00;
    tick();
    repeat (3) tick();
    total++;
    if (sel !== 3'd1 || dut.hold_cnt !== 4'd3) begin
      bad++; $display("FAIL tie_setup: got sel %0d hold %0d want sel 1 hold 3", sel, dut.hold_cnt);
    end
    req = 8'h20;
    tick();
    exp_v = {3'd1, 8'h00, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL tie_gap: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {3'd5, 8'h20, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL tie_next: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    // Move ptr to 4 so the post-reset grant to 0 proves ptr was cleared.
    req = 8'h08;
    tick();
    req = 8'h00;
    repeat (2) tick();
    req = 8'h40;
    din = 8'h40;
    tick();
    exp_v = {3'd6, 8'h40, 1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_grant: got %h want %h", obs, exp_v); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = '0;
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_clear: got %h want %h", obs, exp_v); end
    req = 8'hFF;
    #1;
    rst_n = 1'b1;
    tick();
    exp_v = {3'd0, 8'h01, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_first: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_all_req();
    apply_reset();
    req = 8'hFF;
    din = 8'hAA;
    for (int r = 0; r < 2; r++) begin
      for (int o = 0; o < 8; o++) begin
        for (int c = 0; c < 4; c++) begin
          tick();
          exp_v = {3'(o), 8'(1) << o, 1'b1, ((o % 2) == 1) ? 1'b1 : 1'b0, 1'b0};
          total++;
          if (obs !== exp_v) begin bad++; $display("FAIL all_grant r%0d o%0d c%0d: got %h want %h", r, o, c, obs, exp_v); end
        end
        tick();
        exp_v = {3'(o), 8'h00, 1'b0, 1'b0, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL all_gap r%0d o%0d: got %h want %h", r, o, obs, exp_v); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    #3;
    test_reset();
    test_single();
    test_wrap();
    test_sole();
    test_tie();
    test_reset_mid_grant();
    test_all_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
